id_decode_stage: RTL and testbench

- Pipelined instruction decode stage for the RV32I core, placed between the fetch buffer and the ALU32/execute stage.
- Takes 32-bit instruction words over a valid/ready handshake and produces the fields that ALU32 consumes: `fun` {funct3, funct7}, one-hot `inst_type`, immediate, register indices and an illegal flag.
- Registered output, plus a one-entry skid buffer, so full throughput holds under execute back-pressure.

---
 rtl/rv32_pkg.sv | 56 +++++
 rtl/id_decode_stage_if.sv | 34 +++
 rtl/rv32_imm_gen.sv | 26 ++
 rtl/id_decode_stage.sv | 160 ++++++++++++++++
 tb/tb_id_decode_stage.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, inst_type bit positions, field
// constants and the decoded-entry payload handed to the execute stage.
package rv32_pkg;

    localparam int unsigned XLEN_W = 32;
    localparam int unsigned FUN_W  = 10;
    localparam int unsigned IT_W   = 6;
    localparam int unsigned REG_W  = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int unsigned IT_R = 5;
    localparam int unsigned IT_I = 4;
    localparam int unsigned IT_S = 3;
    localparam int unsigned IT_B = 2;
    localparam int unsigned IT_J = 1;
    localparam int unsigned IT_U = 0;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_SRL  = 3'd5;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4,
        IMM_U    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [FUN_W-1:0]  fun;
        logic [IT_W-1:0]   inst_type;
        logic [XLEN_W-1:0] imm;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [XLEN_W-1:0] pc;
        logic              illegal;
    } dec_entry_t;

endpackage

// File: rtl/id_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface id_decode_stage_if #(
    parameter int unsigned XLEN = rv32_pkg::XLEN_W
) ();

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [9:0]      out_fun;
    logic [5:0]      out_inst_type;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_fun, out_inst_type, out_imm,
               out_rs1, out_rs2, out_rd, out_pc, out_illegal
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_fun, out_inst_type, out_imm,
               out_rs1, out_rs2, out_rd, out_pc, out_illegal
    );

endinterface

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I immediate extraction for a given immediate format.
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0]       inst,
    input  imm_type_e         imm_type,
    output logic [XLEN_W-1:0] imm_c
);

    // The opcode field never contributes to an immediate.
    logic [6:0] unused_opcode;
    assign unused_opcode = inst[6:0];

    always_comb begin
        imm_c = '0;
        case (imm_type)
            IMM_I:   imm_c = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm_c = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm_c = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_J:   imm_c = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_U:   imm_c = {inst[31:12], 12'h000};
            default: imm_c = '0;
        endcase
    end

endmodule

// File: rtl/id_decode_stage.sv
// RV32I decode stage: registered output plus a one-entry skid buffer so the
// fetch side keeps full throughput under execute back-pressure.
module id_decode_stage
    import rv32_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_W,
    parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
    input logic              clk,
    input logic              rst_n,
    id_decode_stage_if.slave bus
);

    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [IT_W-1:0]   it_raw;
    logic [FUN_W-1:0]  fun_raw;
    logic              legal;
    imm_type_e         imm_type;
    logic [XLEN_W-1:0] imm_raw;
    dec_entry_t        dec_c;

    dec_entry_t out_q, out_d;
    dec_entry_t skid_q, skid_d;
    logic       out_valid_q, out_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       in_ready_q, in_ready_d;
    logic       accept;
    logic       slot_free;

    assign opcode = bus.in_inst[6:0];
    assign f3     = bus.in_inst[14:12];
    assign f7     = bus.in_inst[31:25];

    rv32_imm_gen u_imm_gen (
        .inst     (bus.in_inst),
        .imm_type (imm_type),
        .imm_c    (imm_raw)
    );

    // Opcode/field decode; illegal encodings squash type, fun and imm.
    always_comb begin
        it_raw   = '0;
        fun_raw  = '0;
        legal    = 1'b1;
        imm_type = IMM_NONE;
        case (opcode)
            OP_R: begin
                it_raw[IT_R] = 1'b1;
                fun_raw      = {f3, f7};
                legal        = (f7 == F7_ZERO) ||
                               ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL)));
            end
            OP_IMM: begin
                it_raw[IT_I] = 1'b1;
                fun_raw      = {f3, 7'h00};
                imm_type     = IMM_I;
                if (f3 == F3_SLL) begin
                    legal = (f7 == F7_ZERO);
                end else if (f3 == F3_SRL) begin
                    legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
                end
            end
            OP_LOAD, OP_JALR: begin
                it_raw[IT_I] = 1'b1;
                imm_type     = IMM_I;
            end
            OP_STORE: begin
                it_raw[IT_S] = 1'b1;
                imm_type     = IMM_S;
            end
            OP_BRANCH: begin
                it_raw[IT_B] = 1'b1;
                fun_raw      = {f3, 7'h00};
                imm_type     = IMM_B;
                legal        = !((f3 == F3_SLT) || (f3 == F3_SLTU));
            end
            OP_JAL: begin
                it_raw[IT_J] = 1'b1;
                imm_type     = IMM_J;
            end
            OP_LUI, OP_AUIPC: begin
                it_raw[IT_U] = 1'b1;
                imm_type     = IMM_U;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        dec_c           = '0;
        dec_c.fun       = legal ? fun_raw : '0;
        dec_c.inst_type = legal ? it_raw : '0;
        dec_c.imm       = legal ? imm_raw : '0;
        dec_c.rs1       = bus.in_inst[19:15];
        dec_c.rs2       = bus.in_inst[24:20];
        dec_c.rd        = bus.in_inst[11:7];
        dec_c.pc        = XLEN_W'(bus.in_pc);
        dec_c.illegal   = !legal;
    end

    // Flush wins over any accept; a free output slot drains the skid first.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        accept       = bus.in_valid && in_ready_q && !bus.flush;
        slot_free    = !out_valid_q || bus.out_ready;
        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (slot_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec_c;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_c;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_q.pc     <= XLEN_W'(RESET_PC_TAG);
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_fun       = out_q.fun;
    assign bus.out_inst_type = out_q.inst_type;
    assign bus.out_imm       = XLEN'(out_q.imm);
    assign bus.out_rs1       = out_q.rs1;
    assign bus.out_rs2       = out_q.rs2;
    assign bus.out_rd        = out_q.rd;
    assign bus.out_pc        = XLEN'(out_q.pc);
    assign bus.out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode vector table, back-pressure,
// flush and mid-stall reset sequences.
module tb_id_decode_stage;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] inst;
        logic [5:0]  it;
        logic [9:0]  fun;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    vec_t vecs[12];

    id_decode_stage_if bus ();

    id_decode_stage #(
        .XLEN         (32),
        .RESET_PC_TAG (RST_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_entry(input string tag, input logic [31:0] pc, input logic [4:0] rd);
        chk({tag, " valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, " pc"}, bus.out_pc, pc);
        chk({tag, " rd"}, 32'(bus.out_rd), 32'(rd));
    endtask

    // Leaves A (pc 0x200, rd 10) held on the output and B (pc 0x204, rd 11) in the skid.
    task automatic fill_stall();
        drive(1'b1, 32'h00100513, 32'h200, 1'b0, 1'b0);
        edge_sample();
        drive(1'b1, 32'h00200593, 32'h204, 1'b0, 1'b0);
        edge_sample();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        vecs[0]  = '{32'h002081B3, 6'b100000, 10'h000, 32'h00000000, 5'd1, 5'd2,  5'd3,  1'b0};
        vecs[1]  = '{32'h402081B3, 6'b100000, 10'h020, 32'h00000000, 5'd1, 5'd2,  5'd3,  1'b0};
        vecs[2]  = '{32'h40335293, 6'b010000, 10'h280, 32'h00000403, 5'd6, 5'd3,  5'd5,  1'b0};
        vecs[3]  = '{32'hFFF00093, 6'b010000, 10'h000, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1,  1'b0};
        vecs[4]  = '{32'hFE000EE3, 6'b000100, 10'h000, 32'hFFFFFFFC, 5'd0, 5'd0,  5'd29, 1'b0};
        vecs[5]  = '{32'h00000000, 6'b000000, 10'h000, 32'h00000000, 5'd0, 5'd0,  5'd0,  1'b1};
        vecs[6]  = '{32'h4020C1B3, 6'b000000, 10'h000, 32'h00000000, 5'd1, 5'd2,  5'd3,  1'b1};
        vecs[7]  = '{32'h0020A423, 6'b001000, 10'h000, 32'h00000008, 5'd1, 5'd2,  5'd8,  1'b0};
        vecs[8]  = '{32'h123452B7, 6'b000001, 10'h000, 32'h12345000, 5'd8, 5'd3,  5'd5,  1'b0};
        vecs[9]  = '{32'h008000EF, 6'b000010, 10'h000, 32'h00000008, 5'd0, 5'd8,  5'd1,  1'b0};
        vecs[10] = '{32'h00002063, 6'b000000, 10'h000, 32'h00000000, 5'd0, 5'd0,  5'd0,  1'b1};
        vecs[11] = '{32'h40001013, 6'b000000, 10'h000, 32'h00000000, 5'd0, 5'd0,  5'd0,  1'b1};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
        bus.out_ready = 1'b0; bus.flush = 1'b0;
        repeat (2) edge_sample();
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst fun", 32'(bus.out_fun), 32'd0);
        chk("rst imm", bus.out_imm, 32'd0);
        chk("rst pc", bus.out_pc, RST_PC);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream with out_ready=1: every entry visible one edge after accept.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].inst, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
            edge_sample();
            chk($sformatf("v%0d valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'd1);
            chk($sformatf("v%0d type", i), 32'(bus.out_inst_type), 32'(vecs[i].it));
            chk($sformatf("v%0d fun", i), 32'(bus.out_fun), 32'(vecs[i].fun));
            chk($sformatf("v%0d imm", i), bus.out_imm, vecs[i].imm);
            chk($sformatf("v%0d rs1", i), 32'(bus.out_rs1), 32'(vecs[i].rs1));
            chk($sformatf("v%0d rs2", i), 32'(bus.out_rs2), 32'(vecs[i].rs2));
            chk($sformatf("v%0d rd", i), 32'(bus.out_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d illegal", i), 32'(bus.out_illegal), 32'(vecs[i].ill));
            chk($sformatf("v%0d pc", i), bus.out_pc, 32'h100 + 32'(4 * i));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        edge_sample();
        chk("drain valid", 32'(bus.out_valid), 32'd0);

        // Back-pressure: A held, B skidded, C refused until the pipe drains in order.
        fill_stall();
        chk_entry("bp A held", 32'h200, 5'd10);
        chk("bp in_ready low", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 32'h00300613, 32'h208, 1'b0, 1'b0);
        edge_sample();
        chk_entry("bp A still", 32'h200, 5'd10);
        chk("bp C refused", 32'(bus.in_ready), 32'd0);
        edge_sample();
        chk_entry("bp A stall2", 32'h200, 5'd10);
        drive(1'b1, 32'h00300613, 32'h208, 1'b1, 1'b0);
        edge_sample();
        chk_entry("bp B out", 32'h204, 5'd11);
        chk("bp in_ready back", 32'(bus.in_ready), 32'd1);
        edge_sample();
        chk_entry("bp C out", 32'h208, 5'd12);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        edge_sample();
        chk("bp drained", 32'(bus.out_valid), 32'd0);

        // Flush with the skid full and an input offered.
        fill_stall();
        drive(1'b1, 32'h00300613, 32'h208, 1'b0, 1'b1);
        edge_sample();
        chk("flush full valid", 32'(bus.out_valid), 32'd0);
        chk("flush full in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        edge_sample();
        chk("flush full nothing", 32'(bus.out_valid), 32'd0);

        // Flush with skid empty: in_ready=1, yet the flush-cycle input is dropped.
        drive(1'b1, 32'h00100513, 32'h300, 1'b0, 1'b0);
        edge_sample();
        chk_entry("flush1 A held", 32'h300, 5'd10);
        drive(1'b1, 32'h00200593, 32'h304, 1'b0, 1'b1);
        edge_sample();
        chk("flush1 valid", 32'(bus.out_valid), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        edge_sample();
        chk("flush1 dropped", 32'(bus.out_valid), 32'd0);

        // Reset mid-stall.
        fill_stall();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        edge_sample();
        chk("rst2 valid", 32'(bus.out_valid), 32'd0);
        chk("rst2 in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst2 pc", bus.out_pc, RST_PC);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1;
        edge_sample();
        chk("rst2 empty", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
